// File: rtl/gcd_stream.sv
// gcd_stream: iterative binary (Stein) GCD with valid/ready on operands and result.
// Define GCD_CYCLE_COUNT_EN to add the out_cycles accept-to-result counter port.
module gcd_stream #(
    parameter int DATA_WIDTH  = 9,
    parameter int CYCLE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CYCLE_WIDTH-1:0] out_cycles
`endif
);

    localparam int KW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        STRIP,
        REDUCE,
        DONE
    } state_t;

    if (DATA_WIDTH < 2 || CYCLE_WIDTH < 1) begin : g_bad_param
        $error("gcd_stream: DATA_WIDTH must be >= 2 and CYCLE_WIDTH >= 1");
    end

    state_t              state, state_n;
    logic [DATA_WIDTH-1:0] a_r, a_n;
    logic [DATA_WIDTH-1:0] b_r, b_n;
    logic [DATA_WIDTH-1:0] y_r, y_n;
    logic [KW-1:0]         k, k_n;
    logic                  accept;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign y         = y_r;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            y_r   <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            a_r   <= a_n;
            b_r   <= b_n;
            y_r   <= y_n;
            k     <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        y_n     = y_r;
        k_n     = k;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n = a;
                    b_n = b;
                    k_n = '0;
                    // a zero operand short-circuits: gcd(0,x) = x
                    if (a == '0) begin
                        y_n     = b;
                        state_n = DONE;
                    end else if (b == '0) begin
                        y_n     = a;
                        state_n = DONE;
                    end else begin
                        state_n = STRIP;
                    end
                end
            end
            STRIP: begin
                if (!a_r[0] && !b_r[0]) begin
                    a_n = a_r >> 1;
                    b_n = b_r >> 1;
                    k_n = k + KW'(1);
                end else begin
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                if (a_r == b_r) begin
                    y_n     = a_r << k;
                    state_n = DONE;
                end else if (!a_r[0]) begin
                    a_n = a_r >> 1;
                end else if (!b_r[0]) begin
                    b_n = b_r >> 1;
                end else if (a_r > b_r) begin
                    a_n = (a_r - b_r) >> 1;
                end else begin
                    b_n = (b_r - a_r) >> 1;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
        endcase
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CYCLE_WIDTH-1:0] cyc;

    assign out_cycles = cyc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= '0;
        end else if (accept) begin
            cyc <= '0;
        end else if ((state == STRIP || state == REDUCE) && cyc != '1) begin
            cyc <= cyc + CYCLE_WIDTH'(1);
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// tb_gcd_stream: directed vectors against a Euclid reference model.
// Covers zero operands, STRIP path, backpressure and mid-operation reset.
module tb_gcd_stream;

    localparam int DW    = 9;
    localparam int CW    = 8;
    localparam int BOUND = 3 * DW + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] y;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CW-1:0] out_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int exp_y  = 0;

    gcd_stream #(
        .DATA_WIDTH (DW),
        .CYCLE_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .out_cycles(out_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_gcd(input int x, input int z);
        int p = x;
        int q = z;
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Result and handshake check on every cycle a result is presented
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            chk("mon_y", 32'(y), exp_y);
            chk("mon_in_ready_low", 32'(in_ready), 0);
            chk("mon_busy_high", 32'(busy), 1);
        end
    end

    task automatic do_op(input int av, input int bv, input int expv,
                         input int stall, output int lat);
        chk("pre_in_ready", 32'(in_ready), 1);
        a        = DW'(av);
        b        = DW'(bv);
        in_valid = 1'b1;
        out_ready = (stall == 0);
        exp_y    = model_gcd(av, bv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        chk("accept_busy", 32'(busy), 1);
        lat = 0;
        while (!out_valid && lat < BOUND + 2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("result_timeout", 32'(out_valid), 1);
        if (!out_valid) begin
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        chk("y_literal", 32'(y), expv);
`ifdef GCD_CYCLE_COUNT_EN
        chk("out_cycles", 32'(out_cycles), lat);
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = DW'(3);
            b        = DW'(6);
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_y", 32'(y), expv);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_busy", 32'(busy), 0);
        in_valid = 1'b0;
        chk("post_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
    endtask

    int lat;

    initial begin
        chk("model_9_27", model_gcd(9, 27), 9);
        chk("model_49_21", model_gcd(49, 21), 7);
        chk("model_0_37", model_gcd(0, 37), 37);
        chk("model_0_0", model_gcd(0, 0), 0);
        chk("model_256_384", model_gcd(256, 384), 128);

        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_y", 32'(y), 0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("rst_cycles", 32'(out_cycles), 0);
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(9, 27, 9, 0, lat);
        do_op(49, 21, 7, 0, lat);
        do_op(40, 40, 40, 0, lat);
        do_op(250, 190, 10, 0, lat);
        do_op(250, 5, 5, 0, lat);
        do_op(0, 37, 37, 0, lat);
        chk("zero_a_latency", lat, 0);
        do_op(0, 0, 0, 0, lat);
        chk("zero_both_latency", lat, 0);
        do_op(37, 0, 37, 0, lat);
        chk("zero_b_latency", lat, 0);
        do_op(511, 510, 1, 0, lat);
        chk("lat_511_510_ok", 32'(lat + 1 <= BOUND), 1);
        do_op(256, 384, 128, 0, lat);

        do_op(18, 12, 6, 5, lat);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_queued_op", 32'(busy), 0);
        end
        do_op(3, 6, 3, 0, lat);

        a         = DW'(250);
        b         = DW'(190);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_y     = model_gcd(250, 190);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_no_result", 32'(out_valid), 0);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_y", 32'(y), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_idle", 32'(in_ready), 1);
        do_op(12, 18, 6, 0, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
